avg_sequencer: RTL and testbench
================================

Name: avg_sequencer

Overview:
- Time-multiplexed controller for the sum-and-divide averaging datapath.
- Accepts SAMPLES data words one at a time over a valid/ready stream and accumulates them through a single shared adder.
- Then sequences one iterative restoring divider to produce avg = sum / num.
- Replaces the unrolled adder/register chain where area matters; sits between a sample producer and a result consumer.

Parameters:
- DATAWIDTH, 16, width of samples, num and avg
- ACCWIDTH, 32, width of accumulator and dividend; also the number of divide iterations
- SAMPLES, 8, samples per average (>=1); sample counter width is $clog2(SAMPLES+1)

Ports:
- Clk  input  1  clock, all state on rising edge
- Rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  begin a new average; sampled only in IDLE
- num  input  DATAWIDTH  divisor, latched on the accepted start
- busy  output  1  high whenever state != IDLE
- din  input  DATAWIDTH  sample data, unsigned
- din_valid  input  1  sample present
- din_ready  output  1  block can accept a sample
- avg  output  DATAWIDTH  result, registered
- avg_valid  output  1  result present
- avg_ready  input  1  consumer accepts the result
- div_zero  output  1  result produced with num == 0; qualified by avg_valid

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE; acc, cnt, num_q, quotient/remainder, avg = 0.
  - avg_valid, div_zero, din_ready, busy = 0.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE -> ACCUM -> DIVIDE -> DONE -> IDLE.
- IDLE:
  - din_ready=0.
  - start=1: num_q<=num, acc<=0, cnt<=0, div_zero<=0, go ACCUM.
- ACCUM:
  - din_ready=1.
  - On each edge with din_valid&din_ready: acc <= acc + zero-extended din (unsigned, modulo 2^ACCWIDTH), cnt<=cnt+1.
  - The edge accepting sample number SAMPLES moves to DIVIDE. Gaps in din_valid simply stall.
- DIVIDE:
  - din_ready=0.
  - num_q==0: one edge, then DONE with avg<=all ones, div_zero<=1.
  - Otherwise: restoring division, one quotient bit per edge, MSB first, over exactly ACCWIDTH edges. The final edge writes avg <= low DATAWIDTH bits of (acc / num_q), unsigned and truncated, and enters DONE.
- Latency:
  - avg_valid rises ACCWIDTH edges after the edge accepting the last sample.
  - With num_q==0, avg_valid rises 1 edge after that edge.
- DONE:
  - avg_valid=1; avg and div_zero held stable while avg_ready=0.
  - The edge with avg_valid&avg_ready returns to IDLE and clears avg_valid.
  - avg keeps its last value until overwritten by the next result.
- start is ignored in every state except IDLE, including the DONE handshake cycle. The earliest new start is the first cycle back in IDLE.
- num changes after the start edge have no effect.
- avg_ready outside DONE is ignored.

Test Plan:
- Basic average: num=8, samples 10,20,...,80 back-to-back (sum 360) -> avg=45, div_zero=0, avg_valid exactly 32 edges after the 8th accept, busy=1 throughout.
- Divide by zero: num=0, 8 samples of 5 -> avg=16'hFFFF, div_zero=1, avg_valid 1 edge after the last accept.
- Input gaps plus ignored starts: din_valid toggled with 1-3 idle cycles, start pulsed during ACCUM and DIVIDE, num=4, samples 1..8 (sum 36) -> avg=9; start pulses have no effect.
- Output backpressure: avg_ready held low 5 cycles -> avg/avg_valid stable, busy=1, din_ready=0. Then avg_ready=1 for one cycle -> IDLE; start on the same cycle ignored, start next cycle accepted.
- Truncation: 8 samples of 16'hFFFF, num=1 (sum 0x7FFF8) -> avg=16'hFFF8. Repeat with num=3 -> avg=16'hAAA8.
- Reset mid-DIVIDE: Rst=0 at division step 10 -> outputs zero immediately and avg_valid never rises. After release, the basic-average scenario passes again.

Source files
------------

// File: rtl/avg_sequencer.sv
// ---------------------------------------------------------------------------
// avg_sequencer
//
// Time-multiplexed averaging controller. SAMPLES unsigned words arrive one at
// a time on a valid/ready stream and are summed through a single adder. The
// sum is then divided by a divisor latched at start time. The divider is an
// iterative restoring divider that retires one quotient bit per clock. The
// result is then held on a valid/ready output until the consumer takes it.
//
// Ports:
//   Clk        in   clock, all state on rising edge
//   Rst        in   asynchronous active-low reset (0 = reset)
//   start      in   begin a new average, only honoured in IDLE
//   num        in   divisor, latched on the accepted start
//   busy       out  high whenever the controller is not in IDLE
//   din        in   sample data, unsigned
//   din_valid  in   sample present
//   din_ready  out  block can accept a sample (ACCUM only)
//   avg        out  registered result, keeps its value until the next result
//   avg_valid  out  result present
//   avg_ready  in   consumer accepts the result
//   div_zero   out  result was produced with num == 0, qualified by avg_valid
// ---------------------------------------------------------------------------
module avg_sequencer #(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 32,
  parameter int SAMPLES   = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] num,
  output logic                 busy,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DATAWIDTH-1:0] avg,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic                 div_zero
);

  localparam int CNTW  = $clog2(SAMPLES + 1);
  localparam int STEPW = $clog2(ACCWIDTH + 1);

  localparam logic [CNTW-1:0]  LAST_CNT  = CNTW'(SAMPLES - 1);
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(ACCWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;

  // r_acc holds the running sum during ACCUM. During DIVIDE it becomes the
  // dividend/quotient shift register: dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so after ACCWIDTH steps it holds the
  // full quotient.
  logic [ACCWIDTH-1:0]    r_acc;
  logic [CNTW-1:0]        r_cnt;
  logic [DATAWIDTH-1:0]   r_numQ;
  logic [DATAWIDTH-1:0]   r_rem;
  logic [STEPW-1:0]       r_step;
  logic [DATAWIDTH-1:0]   r_avg;
  logic                   r_divZero;

  logic                   w_dinReady;
  logic                   w_busy;
  logic                   w_accept;
  logic [DATAWIDTH:0]     w_remShift;
  logic [DATAWIDTH-1:0]   w_remSub;
  logic                   w_qBit;
  logic [DATAWIDTH-1:0]   w_remNext;

  // One restoring-division step. The remainder is always below the divisor,
  // so the shifted partial remainder fits in DATAWIDTH+1 bits. When the
  // subtraction succeeds, the true difference is below the divisor, so its
  // low DATAWIDTH bits are exact.
  assign w_remShift = {r_rem, r_acc[ACCWIDTH-1]};
  assign w_qBit     = (w_remShift >= {1'b0, r_numQ});
  assign w_remSub   = w_remShift[DATAWIDTH-1:0] - r_numQ;
  assign w_remNext  = w_qBit ? w_remSub : w_remShift[DATAWIDTH-1:0];

  assign w_accept   = din_valid & w_dinReady;

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and the state-derived handshake outputs.
  always_comb begin
    w_nextState = r_state;
    w_dinReady  = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_nextState = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_dinReady = 1'b1;
        if (din_valid && (r_cnt == LAST_CNT)) begin
          w_nextState = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if ((r_numQ == '0) || (r_step == LAST_STEP)) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (avg_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: accumulation, the iterative divide and the result register.
  // A zero divisor short-circuits the divide and yields all ones.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_numQ    <= '0;
      r_rem     <= '0;
      r_step    <= '0;
      r_avg     <= '0;
      r_divZero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_numQ    <= num;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_step    <= '0;
            r_divZero <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= r_acc + ACCWIDTH'(din);
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        S_DIVIDE: begin
          if (r_numQ == '0) begin
            r_avg     <= '1;
            r_divZero <= 1'b1;
          end else begin
            r_rem  <= w_remNext;
            r_acc  <= {r_acc[ACCWIDTH-2:0], w_qBit};
            r_step <= r_step + STEPW'(1);
            if (r_step == LAST_STEP) begin
              r_avg <= {r_acc[DATAWIDTH-2:0], w_qBit};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = w_busy;
  assign din_ready = w_dinReady;
  assign avg       = r_avg;
  assign avg_valid = (r_state == S_DONE);
  assign div_zero  = r_divZero;

endmodule

// File: tb/tb_avg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_avg_sequencer
//
// Directed self-checking bench for avg_sequencer with default parameters
// (DATAWIDTH=16, ACCWIDTH=32, SAMPLES=8). Inputs are driven and outputs are
// sampled on the falling clock edge, so every rising edge in between sees
// stable inputs.
// ---------------------------------------------------------------------------
module tb_avg_sequencer;

  logic        Clk;
  logic        Rst;
  logic        start;
  logic [15:0] num;
  logic        busy;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] avg;
  logic        avg_valid;
  logic        avg_ready;
  logic        div_zero;

  int errors;
  int checks;
  int busyLow;

  avg_sequencer #(
    .DATAWIDTH(16),
    .ACCWIDTH (32),
    .SAMPLES  (8)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .num      (num),
    .busy     (busy),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .avg      (avg),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .div_zero (div_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Absolute time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulse start for one cycle, then scramble num to show it is not re-read.
  task automatic startOp(input logic [15:0] n);
    start = 1'b1;
    num   = n;
    @(negedge Clk);
    start = 1'b0;
    num   = 16'hDEAD;
  endtask

  // Present eight samples. Optional idle gaps of 1-3 cycles go between
  // samples, and start may be pulsed during those gaps (num=1 while pulsing).
  task automatic feedSamples(input logic [15:0] s [8], input bit withGaps,
                             input bit pulseStart);
    for (int i = 0; i < 8; i++) begin
      din       = s[i];
      din_valid = 1'b1;
      @(negedge Clk);
      if (!busy) busyLow++;
      din_valid = 1'b0;
      if (withGaps && i < 7) begin
        for (int g = 0; g < (i % 3) + 1; g++) begin
          start = pulseStart;
          num   = 16'd1;
          @(negedge Clk);
          start = 1'b0;
        end
      end
    end
  endtask

  // Count rising edges from the last accept to avg_valid, bounded at 100.
  task automatic waitResult(output int edges, input bit pulseStart);
    edges = 0;
    while (!avg_valid && edges < 100) begin
      start = pulseStart && (edges < 5);
      num   = 16'd1;
      @(negedge Clk);
      edges++;
      if (!busy) busyLow++;
    end
    start = 1'b0;
  endtask

  task automatic acceptResult();
    avg_ready = 1'b1;
    @(negedge Clk);
    avg_ready = 1'b0;
  endtask

  task automatic applyStimulusIdle();
    start     = 1'b0;
    num       = 16'd0;
    din       = 16'd0;
    din_valid = 1'b0;
    avg_ready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    applyStimulusIdle();
    repeat (2) @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || avg_valid !== 1'b0 ||
        div_zero !== 1'b0 || avg !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b rdy=%b vld=%b dz=%b avg=%h required all 0",
               busy, din_ready, avg_valid, div_zero, avg);
    end
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [15:0] s [8];
    int edges;
    s = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    busyLow = 0;
    startOp(16'd8);
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_accum_entry: got busy=%b rdy=%b required 1 1", busy, din_ready);
    end
    feedSamples(s, 1'b0, 1'b0);
    waitResult(edges, 1'b0);
    checks++;
    if (edges !== 32) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d edges required 32", edges);
    end
    checks++;
    if (avg !== 16'd45 || div_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_avg: got avg=%0d dz=%b required avg=45 dz=0", avg, div_zero);
    end
    checks++;
    if (busyLow !== 0 || din_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy: got busyLow=%0d rdy=%b required 0 0", busyLow, din_ready);
    end
    acceptResult();
    checks++;
    if (busy !== 1'b0 || avg_valid !== 1'b0 || avg !== 16'd45) begin
      errors++;
      $display("[TB] FAIL basic_handshake: got busy=%b vld=%b avg=%0d required 0 0 45",
               busy, avg_valid, avg);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] s [8];
    int edges;
    s = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
    startOp(16'd0);
    feedSamples(s, 1'b0, 1'b0);
    waitResult(edges, 1'b0);
    checks++;
    if (edges !== 1) begin
      errors++;
      $display("[TB] FAIL dz_latency: got %0d edges required 1", edges);
    end
    checks++;
    if (avg !== 16'hFFFF || div_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dz_result: got avg=%h dz=%b required ffff 1", avg, div_zero);
    end
    acceptResult();
  endtask

  task automatic test_gaps_ignored_starts();
    logic [15:0] s [8];
    int edges;
    s = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    busyLow = 0;
    startOp(16'd4);
    feedSamples(s, 1'b1, 1'b1);
    waitResult(edges, 1'b1);
    checks++;
    if (avg !== 16'd9 || div_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gaps_avg: got avg=%0d dz=%b required 9 0", avg, div_zero);
    end
    checks++;
    if (edges !== 32 || busyLow !== 0) begin
      errors++;
      $display("[TB] FAIL gaps_timing: got edges=%0d busyLow=%0d required 32 0", edges, busyLow);
    end
    acceptResult();
  endtask

  task automatic test_backpressure_truncation();
    logic [15:0] s [8];
    int edges;
    int unstable;
    for (int i = 0; i < 8; i++) s[i] = 16'hFFFF;
    startOp(16'd1);
    feedSamples(s, 1'b0, 1'b0);
    waitResult(edges, 1'b0);
    checks++;
    if (avg !== 16'hFFF8 || edges !== 32) begin
      errors++;
      $display("[TB] FAIL trunc_div1: got avg=%h edges=%0d required fff8 32", avg, edges);
    end
    unstable = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (avg !== 16'hFFF8 || avg_valid !== 1'b1 || busy !== 1'b1 || din_ready !== 1'b0)
        unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: got %0d unstable cycles required 0", unstable);
    end
    avg_ready = 1'b1;
    start     = 1'b1;
    num       = 16'd3;
    @(negedge Clk);
    avg_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if (busy !== 1'b0 || avg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_in_handshake: got busy=%b vld=%b required 0 0", busy, avg_valid);
    end
    startOp(16'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_after_idle: got busy=%b required 1", busy);
    end
    feedSamples(s, 1'b0, 1'b0);
    waitResult(edges, 1'b0);
    checks++;
    if (avg !== 16'hAAA8 || div_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trunc_div3: got avg=%h dz=%b required aaa8 0", avg, div_zero);
    end
    acceptResult();
  endtask

  task automatic test_reset_mid_divide();
    logic [15:0] s [8];
    int validSeen;
    s = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    startOp(16'd8);
    feedSamples(s, 1'b0, 1'b0);
    repeat (10) @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    checks++;
    if (avg !== 16'd0 || avg_valid !== 1'b0 || busy !== 1'b0 ||
        din_ready !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_divide: got avg=%h vld=%b busy=%b rdy=%b dz=%b required all 0",
               avg, avg_valid, busy, din_ready, div_zero);
    end
    @(negedge Clk);
    Rst = 1'b1;
    validSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (avg_valid !== 1'b0 || busy !== 1'b0) validSeen++;
    end
    checks++;
    if (validSeen !== 0) begin
      errors++;
      $display("[TB] FAIL no_partial_result: got %0d active cycles required 0", validSeen);
    end
    test_basic();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    busyLow = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_gaps_ignored_starts();
    test_backpressure_truncation();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
